// File: rtl/rep_string_pkg.sv
// rep_string_pkg: shared types and constants for the string-instruction sequencer.
// Latency: n/a (types only).
// Backpressure: n/a.
`timescale 1ns/1ps
package rep_string_pkg;

  // String opcode as decoded by the front end.
  typedef enum logic [1:0] {
    OP_MOVS = 2'b00,
    OP_STOS = 2'b01,
    OP_LODS = 2'b10,
    OP_RSVD = 2'b11
  } str_op_t;

  // Element size encodings carried on mem_size.
  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_WORD  = 2'b01;
  localparam logic [1:0] SZ_DWORD = 2'b10;

  // alu2 operation codes driven by the sequencer.
  localparam logic [3:0] OP_PASS_SR1 = 4'b0000;
  localparam logic [3:0] OP_STRIDX   = 4'b0101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHK,
    ST_RD,
    ST_WR,
    ST_UPD_SI,
    ST_UPD_DI,
    ST_UPD_CX,
    ST_FIN
  } state_t;

endpackage

// File: rtl/rep_string_seq.sv
// rep_string_seq: execute-stage sequencer for MOVS/STOS/LODS with optional REP.
// Latency: start->CHK next cycle; each iteration is RD/WR handshakes plus 1-cycle
//   UPD_SI/UPD_DI/UPD_CX steps; done pulses in FIN, busy drops the cycle after.
// Backpressure: mem_rd_req/mem_wr_req hold until their ack; flush drops them at once.
// Ports:
//   clk, rst (sync, active-low)         clock / reset
//   start, str_op, rep, size_in,        instruction launch and operands latched in IDLE
//   ecx_in, eax_in, df_in
//   flush                               abort; no done, IDLE next cycle
//   mem_rd_*, mem_wr_*, mem_size        memory request/ack handshakes
//   alu2_op, alu2_sr2_sel, alu2_df,     alu2 control for ESI/EDI stepping
//   alu_res2
//   esi/edi/ecx/eax_wr_en, ecx_out      register-file write strobes
//   busy, done                          decode stall and completion pulse
`timescale 1ns/1ps
module rep_string_seq
  import rep_string_pkg::*;
#(
  parameter int         DATA_W    = 32,
  parameter logic [3:0] OP_STRIDX = 4'b0101
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        str_op,
  input  logic              rep,
  input  logic [1:0]        size_in,
  input  logic [DATA_W-1:0] ecx_in,
  input  logic [DATA_W-1:0] eax_in,
  input  logic              df_in,
  input  logic              flush,
  output logic              mem_rd_req,
  input  logic              mem_rd_ack,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_req,
  input  logic              mem_wr_ack,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic [1:0]        mem_size,
  output logic [3:0]        alu2_op,
  output logic              alu2_sr2_sel,
  output logic              alu2_df,
  input  logic [DATA_W-1:0] alu_res2,
  output logic              esi_wr_en,
  output logic              edi_wr_en,
  output logic              ecx_wr_en,
  output logic [DATA_W-1:0] ecx_out,
  output logic              eax_wr_en,
  output logic              busy,
  output logic              done
);

  localparam logic [DATA_W-1:0] CNT_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  state_t            state;
  str_op_t           op_q;
  logic              rep_q;
  logic              df_q;
  logic [1:0]        size_q;
  logic [DATA_W-1:0] count_q;
  logic [DATA_W-1:0] eax_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [DATA_W-1:0] ecx_out_q;
  logic              rd_req_q;
  logic              wr_req_q;
  logic              esi_we_q;
  logic              edi_we_q;
  logic              ecx_we_q;
  logic              done_q;
  logic              busy_q;
  logic              sr2_sel_q;
  logic [3:0]        alu_op_q;
  logic              abort;

  // alu2 result is consumed by the register file directly, not by this block.
  logic unused_alu_res2;
  assign unused_alu_res2 = ^alu_res2;

  assign abort = flush && (state != ST_IDLE);

  // Outputs are registered as the state is entered; flush masks the
  // side-effecting ones in its own cycle so nothing is issued after an abort.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      op_q      <= OP_MOVS;
      rep_q     <= 1'b0;
      df_q      <= 1'b0;
      size_q    <= 2'b00;
      count_q   <= '0;
      eax_q     <= '0;
      wr_data_q <= '0;
      ecx_out_q <= '0;
      rd_req_q  <= 1'b0;
      wr_req_q  <= 1'b0;
      esi_we_q  <= 1'b0;
      edi_we_q  <= 1'b0;
      ecx_we_q  <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      sr2_sel_q <= 1'b0;
      alu_op_q  <= OP_PASS_SR1;
    end else begin
      // Single-cycle strobes default low every cycle.
      esi_we_q  <= 1'b0;
      edi_we_q  <= 1'b0;
      ecx_we_q  <= 1'b0;
      done_q    <= 1'b0;
      sr2_sel_q <= 1'b0;
      alu_op_q  <= OP_PASS_SR1;
      if (abort) begin
        state    <= ST_IDLE;
        rd_req_q <= 1'b0;
        wr_req_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              op_q    <= str_op_t'(str_op);
              rep_q   <= rep;
              size_q  <= size_in;
              df_q    <= df_in;
              count_q <= ecx_in;
              eax_q   <= eax_in;
              busy_q  <= 1'b1;
              state   <= ST_CHK;
            end
          end
          ST_CHK: begin
            // REP with zero count performs no iteration at all.
            if ((rep_q && (count_q == '0)) || (op_q == OP_RSVD)) begin
              done_q <= 1'b1;
              state  <= ST_FIN;
            end else if (op_q == OP_STOS) begin
              wr_data_q <= eax_q;
              wr_req_q  <= 1'b1;
              state     <= ST_WR;
            end else begin
              rd_req_q <= 1'b1;
              state    <= ST_RD;
            end
          end
          ST_RD: begin
            if (mem_rd_ack) begin
              rd_req_q <= 1'b0;
              if (op_q == OP_MOVS) begin
                wr_data_q <= mem_rd_data;
                wr_req_q  <= 1'b1;
                state     <= ST_WR;
              end else begin
                alu_op_q <= OP_STRIDX;
                esi_we_q <= 1'b1;
                state    <= ST_UPD_SI;
              end
            end
          end
          ST_WR: begin
            if (mem_wr_ack) begin
              wr_req_q <= 1'b0;
              alu_op_q <= OP_STRIDX;
              if (op_q == OP_MOVS) begin
                esi_we_q <= 1'b1;
                state    <= ST_UPD_SI;
              end else begin
                sr2_sel_q <= 1'b1;
                edi_we_q  <= 1'b1;
                state     <= ST_UPD_DI;
              end
            end
          end
          ST_UPD_SI: begin
            if (op_q == OP_MOVS) begin
              alu_op_q  <= OP_STRIDX;
              sr2_sel_q <= 1'b1;
              edi_we_q  <= 1'b1;
              state     <= ST_UPD_DI;
            end else begin
              ecx_we_q  <= rep_q;
              ecx_out_q <= rep_q ? (count_q - CNT_ONE) : ecx_out_q;
              state     <= ST_UPD_CX;
            end
          end
          ST_UPD_DI: begin
            ecx_we_q  <= rep_q;
            ecx_out_q <= rep_q ? (count_q - CNT_ONE) : ecx_out_q;
            state     <= ST_UPD_CX;
          end
          ST_UPD_CX: begin
            if (rep_q) begin
              count_q <= count_q - CNT_ONE;
              if (count_q == CNT_ONE) begin
                done_q <= 1'b1;
                state  <= ST_FIN;
              end else begin
                state <= ST_CHK;
              end
            end else begin
              done_q <= 1'b1;
              state  <= ST_FIN;
            end
          end
          ST_FIN: begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
          default: begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign mem_rd_req   = rd_req_q & ~abort;
  assign mem_wr_req   = wr_req_q & ~abort;
  assign esi_wr_en    = esi_we_q & ~abort;
  assign edi_wr_en    = edi_we_q & ~abort;
  assign ecx_wr_en    = ecx_we_q & ~abort;
  assign done         = done_q & ~abort;
  // Read data is only valid in the ack cycle, so the EAX write rides on the ack.
  assign eax_wr_en    = (state == ST_RD) && (op_q == OP_LODS) && mem_rd_ack && !flush;
  assign mem_wr_data  = wr_data_q;
  assign mem_size     = size_q;
  assign alu2_op      = alu_op_q;
  assign alu2_sr2_sel = sr2_sel_q;
  assign alu2_df      = df_q;
  assign ecx_out      = ecx_out_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_rep_string_seq.sv
`timescale 1ns/1ps
module tb_rep_string_seq;

  localparam int EV_NONE = 0, EV_RD = 1, EV_WR = 2, EV_EAX = 3;
  localparam int EV_ESI = 4, EV_EDI = 5, EV_ECX = 6, EV_DONE = 7;

  logic        clk = 1'b0;
  logic        rst, start, rep, df_in, flush;
  logic [1:0]  str_op, size_in;
  logic [31:0] ecx_in, eax_in;
  logic        mem_rd_req, mem_rd_ack, mem_wr_req, mem_wr_ack;
  logic [31:0] mem_rd_data, mem_wr_data, alu_res2, ecx_out;
  logic [1:0]  mem_size;
  logic [3:0]  alu2_op;
  logic        alu2_sr2_sel, alu2_df, esi_wr_en, edi_wr_en, ecx_wr_en, eax_wr_en;
  logic        busy, done;
  logic [79:0] outs;

  rep_string_seq #(.DATA_W(32), .OP_STRIDX(4'b0101)) dut (
    .clk(clk), .rst(rst), .start(start), .str_op(str_op), .rep(rep),
    .size_in(size_in), .ecx_in(ecx_in), .eax_in(eax_in), .df_in(df_in),
    .flush(flush), .mem_rd_req(mem_rd_req), .mem_rd_ack(mem_rd_ack),
    .mem_rd_data(mem_rd_data), .mem_wr_req(mem_wr_req), .mem_wr_ack(mem_wr_ack),
    .mem_wr_data(mem_wr_data), .mem_size(mem_size), .alu2_op(alu2_op),
    .alu2_sr2_sel(alu2_sr2_sel), .alu2_df(alu2_df), .alu_res2(alu_res2),
    .esi_wr_en(esi_wr_en), .edi_wr_en(edi_wr_en), .ecx_wr_en(ecx_wr_en),
    .ecx_out(ecx_out), .eax_wr_en(eax_wr_en), .busy(busy), .done(done)
  );

  assign outs = {mem_rd_req, mem_wr_req, mem_wr_data, mem_size, alu2_op, alu2_sr2_sel,
                 alu2_df, esi_wr_en, edi_wr_en, ecx_wr_en, ecx_out, eax_wr_en, busy, done};

  always #10 clk = ~clk;

  typedef struct {
    int          kind;
    logic [95:0] val;
  } ev_t;

  ev_t         exp_q[$];
  logic [31:0] rd_data_q[$];
  int n_checks = 0, n_fail = 0;
  int cyc = 0, start_cyc = 0, done_cyc = 0;
  int done_cnt = 0, ecx_cnt = 0, req_cycles = 0;
  int rd_lat = 1, wr_lat = 1, rd_cnt = 0, wr_cnt = 0;
  logic rd_pend_p = 1'b0, wr_pend_p = 1'b0, done_prev = 1'b0;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input logic [95:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic got_ev(input int kind, input logic [95:0] val);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("sb_extra_event", 96'(kind), 96'(EV_NONE));
    end else begin
      e = exp_q.pop_front();
      check("sb_event_kind", 96'(kind), 96'(e.kind));
      check("sb_event_val", val, e.val);
    end
  endtask

  // Reference model: expected output events for one instruction.
  task automatic model_op(input logic [1:0] op, input logic rp, input logic [1:0] sz,
                          input logic [31:0] ecx, input logic [31:0] eax, input logic df,
                          input logic [31:0] base);
    int n;
    logic [31:0] cnt, d;
    logic [5:0] esi_v, edi_v;
    esi_v = {df, 1'b0, 4'b0101};
    edi_v = {df, 1'b1, 4'b0101};
    n = (op == 2'b11) ? 0 : (rp ? int'(ecx) : 1);
    for (int i = 0; i < n; i++) begin
      cnt = ecx - 32'(i);
      d   = base + 32'(i);
      case (op)
        2'b00: begin
          rd_data_q.push_back(d);
          push_ev(EV_RD, 96'(sz));
          push_ev(EV_WR, 96'({sz, d}));
          push_ev(EV_ESI, 96'(esi_v));
          push_ev(EV_EDI, 96'(edi_v));
        end
        2'b01: begin
          push_ev(EV_WR, 96'({sz, eax}));
          push_ev(EV_EDI, 96'(edi_v));
        end
        default: begin
          rd_data_q.push_back(d);
          push_ev(EV_RD, 96'(sz));
          push_ev(EV_EAX, 96'(d));
          push_ev(EV_ESI, 96'(esi_v));
        end
      endcase
      if (rp) push_ev(EV_ECX, 96'(cnt - 32'd1));
    end
    push_ev(EV_DONE, 96'(0));
  endtask

  task automatic do_start(input logic [1:0] op, input logic rp, input logic [1:0] sz,
                          input logic [31:0] ecx, input logic [31:0] eax, input logic df);
    @(negedge clk); #1;
    str_op = op; rep = rp; size_in = sz; ecx_in = ecx; eax_in = eax; df_in = df;
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 96'(busy), 96'(1));
  endtask

  task automatic wait_done(input int budget);
    int d0, k;
    d0 = done_cnt;
    k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check("done_timeout", 96'(done_cnt != d0), 96'(1));
    @(negedge clk); #5;
    check("sb_empty", 96'(exp_q.size()), 96'(0));
  endtask

  always @(posedge clk) begin
    cyc++;
    rd_pend_p <= mem_rd_req && !mem_rd_ack && !flush && rst;
    wr_pend_p <= mem_wr_req && !mem_wr_ack && !flush && rst;
  end

  // Memory responder: ack after a configurable number of waiting cycles.
  always @(negedge clk) begin
    #3;
    mem_rd_ack = 1'b0;
    mem_wr_ack = 1'b0;
    if (mem_rd_req) begin
      if (rd_cnt >= rd_lat) begin
        mem_rd_ack = 1'b1;
        if (rd_data_q.size() > 0) mem_rd_data = rd_data_q.pop_front();
        else mem_rd_data = 32'hDEAD_BEEF;
        rd_cnt = 0;
      end else rd_cnt++;
    end else rd_cnt = 0;
    if (mem_wr_req) begin
      if (wr_cnt >= wr_lat) begin
        mem_wr_ack = 1'b1;
        wr_cnt = 0;
      end else wr_cnt++;
    end else wr_cnt = 0;
  end

  // Monitor: turns DUT activity into events and checks them against the scoreboard.
  always @(negedge clk) begin
    #4;
    if (done_prev) check("busy_after_done", 96'(busy), 96'(0));
    done_prev = done;
    if (mem_rd_req && mem_wr_req) check("req_exclusive", 96'({mem_rd_req, mem_wr_req}), 96'(2'b10));
    if (rd_pend_p && !flush) check("rd_req_hold", 96'(mem_rd_req), 96'(1));
    if (wr_pend_p && !flush) check("wr_req_hold", 96'(mem_wr_req), 96'(1));
    if (mem_rd_req || mem_wr_req) req_cycles++;
    if (mem_rd_req && mem_rd_ack) got_ev(EV_RD, 96'(mem_size));
    if (mem_wr_req && mem_wr_ack) got_ev(EV_WR, 96'({mem_size, mem_wr_data}));
    if (eax_wr_en) got_ev(EV_EAX, 96'(mem_rd_data));
    if (esi_wr_en) got_ev(EV_ESI, 96'({alu2_df, alu2_sr2_sel, alu2_op}));
    if (edi_wr_en) got_ev(EV_EDI, 96'({alu2_df, alu2_sr2_sel, alu2_op}));
    if (ecx_wr_en) begin
      ecx_cnt++;
      got_ev(EV_ECX, 96'(ecx_out));
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      got_ev(EV_DONE, 96'(0));
    end
  end

  initial begin
    int d0, rc, e0, k;
    rst = 1'b0; start = 1'b0; rep = 1'b0; df_in = 1'b0; flush = 1'b0;
    str_op = 2'b00; size_in = 2'b00; ecx_in = '0; eax_in = '0;
    mem_rd_ack = 1'b0; mem_wr_ack = 1'b0; mem_rd_data = '0; alu_res2 = '0;

    repeat (3) @(negedge clk);
    #5 check("reset_outputs", 96'(outs), 96'(0));
    @(negedge clk); #1 rst = 1'b1;

    // MOVS dword, REP, ECX=3, DF=0, acks one cycle late.
    rd_lat = 1; wr_lat = 1; d0 = done_cnt;
    model_op(2'b00, 1'b1, 2'b10, 32'd3, 32'h0, 1'b0, 32'h1000_0000);
    do_start(2'b00, 1'b1, 2'b10, 32'd3, 32'h0, 1'b0);
    wait_done(200);
    check("movs_done_count", 96'(done_cnt - d0), 96'(1));

    // STOS byte, REP, ECX=0: zero iterations, done two cycles after start.
    rc = req_cycles; e0 = ecx_cnt;
    model_op(2'b01, 1'b1, 2'b00, 32'd0, 32'h55, 1'b0, 32'h0);
    do_start(2'b01, 1'b1, 2'b00, 32'd0, 32'h55, 1'b0);
    wait_done(20);
    check("stos_zero_latency", 96'(done_cyc - start_cyc), 96'(2));
    check("stos_zero_no_req", 96'(req_cycles - rc), 96'(0));
    check("stos_zero_no_ecx", 96'(ecx_cnt - e0), 96'(0));

    // LODS word, no REP, DF=1, ECX=5, immediate read ack.
    rd_lat = 0; e0 = ecx_cnt;
    model_op(2'b10, 1'b0, 2'b01, 32'd5, 32'h0, 1'b1, 32'hA5A5_0001);
    do_start(2'b10, 1'b0, 2'b01, 32'd5, 32'h0, 1'b1);
    wait_done(100);
    check("lods_no_ecx", 96'(ecx_cnt - e0), 96'(0));

    // MOVS REP ECX=4, flushed while the second write is waiting.
    rd_lat = 0; wr_lat = 2; d0 = done_cnt; e0 = ecx_cnt;
    rd_data_q.push_back(32'h2000_0000);
    rd_data_q.push_back(32'h2000_0001);
    push_ev(EV_RD, 96'(2'b10));
    push_ev(EV_WR, 96'({2'b10, 32'h2000_0000}));
    push_ev(EV_ESI, 96'(6'b000101));
    push_ev(EV_EDI, 96'(6'b010101));
    push_ev(EV_ECX, 96'(32'd3));
    push_ev(EV_RD, 96'(2'b10));
    do_start(2'b00, 1'b1, 2'b10, 32'd4, 32'h0, 1'b0);
    k = 0;
    while (!(ecx_cnt > e0 && mem_wr_req) && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    check("flush_wait_timeout", 96'(k < 100), 96'(1));
    flush = 1'b1;
    #1 check("flush_req_drop", 96'(mem_wr_req), 96'(0));
    @(negedge clk); #1;
    flush = 1'b0;
    check("flush_busy_low", 96'(busy), 96'(0));
    check("flush_last_ecx", 96'(ecx_out), 96'(3));
    repeat (3) @(negedge clk);
    #5 check("flush_no_done", 96'(done_cnt - d0), 96'(0));
    check("flush_sb_empty", 96'(exp_q.size()), 96'(0));

    // start while busy is ignored; then a reserved op gives only done.
    rd_lat = 1; wr_lat = 1; d0 = done_cnt;
    model_op(2'b00, 1'b0, 2'b01, 32'd7, 32'h0, 1'b1, 32'h3000_0000);
    do_start(2'b00, 1'b0, 2'b01, 32'd7, 32'h0, 1'b1);
    @(negedge clk); #1;
    str_op = 2'b01; rep = 1'b1; ecx_in = 32'd9; eax_in = 32'h7777; start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    wait_done(100);
    repeat (3) @(negedge clk);
    #5 check("busy_start_ignored", 96'(done_cnt - d0), 96'(1));
    rc = req_cycles;
    model_op(2'b11, 1'b1, 2'b10, 32'd4, 32'h0, 1'b0, 32'h0);
    do_start(2'b11, 1'b1, 2'b10, 32'd4, 32'h0, 1'b0);
    wait_done(20);
    check("rsvd_no_req", 96'(req_cycles - rc), 96'(0));

    // Reset while a read is outstanding, then a normal run.
    rd_lat = 20;
    do_start(2'b10, 1'b1, 2'b10, 32'd2, 32'h0, 1'b0);
    k = 0;
    while (!mem_rd_req && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    check("rst_rd_req_seen", 96'(mem_rd_req), 96'(1));
    rst = 1'b0;
    @(negedge clk); #5;
    check("rst_mid_outputs", 96'(outs), 96'(0));
    @(negedge clk); #1 rst = 1'b1;
    rd_data_q.delete();
    check("rst_sb_empty", 96'(exp_q.size()), 96'(0));
    rd_lat = 1; wr_lat = 0;
    model_op(2'b01, 1'b1, 2'b01, 32'd2, 32'h0000_CAFE, 1'b1, 32'h0);
    do_start(2'b01, 1'b1, 2'b01, 32'd2, 32'h0000_CAFE, 1'b1);
    wait_done(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rep_string_seq.md
Name: rep_string_seq

Overview:
- Sequences x86 string instructions (MOVS, STOS, LODS, with or without REP) in the execute stage.
- Drives alu2 each iteration to step ESI/EDI by the direction flag, decrements ECX, and issues memory read/write requests with handshakes.
- Holds the front end stalled via busy until the string operation completes or is flushed.

Parameters:
- DATA_W, 32, width of ECX, data and alu2 result paths.
- OP_STRIDX, 4'b0101, alu2_op encoding for DF-directed string index step.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous and active-low.
- start  in  1  one-cycle pulse; decoded string instruction accepted when busy=0.
- str_op  in  2  00 MOVS, 01 STOS, 10 LODS, 11 reserved (treated as NOP, done pulse only).
- rep  in  1  REP prefix present.
- size_in  in  2  element size: 00 byte, 01 word, 10 dword.
- ecx_in  in  DATA_W  ECX value at start.
- eax_in  in  DATA_W  EAX value at start (STOS source).
- df_in  in  1  direction flag at start.
- flush  in  1  pipeline flush / abort.
- mem_rd_req  out  1  read request at ESI.
- mem_rd_ack  in  1  read complete; mem_rd_data valid this cycle.
- mem_rd_data  in  DATA_W  read data.
- mem_wr_req  out  1  write request at EDI.
- mem_wr_ack  in  1  write accepted.
- mem_wr_data  out  DATA_W  write data.
- mem_size  out  2  size_in latched; drives mem_rd_size/mem_wr_size and alu2 step.
- alu2_op  out  4  OP_STRIDX while updating, else 4'b0000.
- alu2_sr2_sel  out  1  0 selects ESI, 1 selects EDI as alu2 sr2.
- alu2_df  out  1  latched DF, drives alu2 DF_in.
- alu_res2  in  DATA_W  alu2 result, same cycle as alu2_op.
- esi_wr_en  out  1  write alu_res2 to ESI.
- edi_wr_en  out  1  write alu_res2 to EDI.
- ecx_wr_en  out  1  write ecx_out to ECX.
- ecx_out  out  DATA_W  decremented count.
- eax_wr_en  out  1  write mem_rd_data to EAX (LODS).
- busy  out  1  stall to decode.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=0 at posedge): state IDLE, all outputs 0, latched size/df/op/count/data cleared.
- Start acceptance: start while IDLE latches str_op, rep, size_in, df_in, ecx_in and eax_in, then goes to CHK. busy=1 from the next cycle until the cycle after done. start while busy is ignored.
- CHK:
  - rep=1 and count=0: go to FIN, zero iterations, no memory access.
  - MOVS/LODS: go to RD.
  - STOS: go to WR with mem_wr_data=eax.
  - reserved op: go to FIN.
- RD: mem_rd_req held high until mem_rd_ack.
  - On ack, MOVS latches data into mem_wr_data and goes to WR.
  - On ack, LODS pulses eax_wr_en for one cycle and goes to UPD_SI.
- WR: mem_wr_req held high until mem_wr_ack.
  - On ack, MOVS goes to UPD_SI; STOS goes to UPD_DI.
- UPD_SI (one cycle): alu2_op=OP_STRIDX, sr2_sel=0, esi_wr_en=1.
  - Next state: MOVS goes to UPD_DI; LODS goes to UPD_CX.
- UPD_DI (one cycle): alu2_op=OP_STRIDX, sr2_sel=1, edi_wr_en=1, then UPD_CX.
- UPD_CX (one cycle):
  - rep=1: ecx_out=count-1, ecx_wr_en=1, count<=count-1. Go to FIN if count-1==0, else back to CHK.
  - rep=0: no ECX write; go to FIN.
- FIN: done=1 for one cycle, then IDLE.
- Count arithmetic: modulo 2^DATA_W. ecx_in=0 with rep=1 performs zero iterations (no wrap to 0xFFFFFFFF).
- Handshake rules: at most one of mem_rd_req/mem_wr_req high; a request never drops before its ack. An ack in the same cycle as the request's first assertion is legal.
- Flush: flush in any non-IDLE state drops all requests and write enables that cycle, forces IDLE next cycle, and produces no done. Registers written in earlier iterations stay written, so the instruction restarts from architectural state. Flush wins over a simultaneous ack.
- Reset mid-operation behaves like flush, but also clears all latched state.

Decomposition:
- Shared package rep_string_pkg: str_op_t enum (MOVS/STOS/LODS/RSVD), size encodings, alu2_op constants (OP_PASS_SR1=4'b0000, OP_STRIDX=4'b0101), state enum.
- Single module; no sub-module needed. The ECX down-counter stays inline.

Test Plan:
- MOVS dword, rep=1, ecx_in=3, df=0, acks one cycle late -> 3 rd/wr pairs; esi_wr_en and edi_wr_en 3 each; ecx_out 2,1,0; one done; busy low the cycle after done.
- STOS byte, rep=1, ecx_in=0 -> no mem_wr_req, no register writes, done 2 cycles after start.
- LODS word, rep=0, df=1, ecx_in=5 -> one read, eax_wr_en with mem_rd_data, esi_wr_en once, no ecx_wr_en, no edi_wr_en.
- MOVS rep=1, ecx_in=4, flush on the 2nd iteration while mem_wr_req waits -> request drops, IDLE next cycle, no done, last ecx_out=3.
- start asserted while busy, plus a reserved str_op=11 after completion -> busy start ignored; reserved op gives done only, no requests.
- rst=0 during RD with mem_rd_req high -> all outputs 0 next cycle; a new start then runs normally.
